// File: rtl/boxcar_pkg.sv
// boxcar_pkg: shared widths and saturation limits for the boxcar decimation chain
package boxcar_pkg;
  localparam int DATA_WIDTH    = 8;
  localparam int NUM_SAMPLES   = 2;
  localparam int DEF_IN_WIDTH  = DATA_WIDTH + $clog2(NUM_SAMPLES);
  localparam int DEF_OUT_WIDTH = 8;
  localparam int DEF_SHIFT     = 1;
  localparam int DEF_DECIM     = 2;
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction
  localparam int SAT_MAX_DEF = sat_max(DEF_OUT_WIDTH);
  localparam int SAT_MIN_DEF = sat_min(DEF_OUT_WIDTH);
endpackage

// File: rtl/fifo2.sv
// fifo2: two-entry FIFO; a write into a full FIFO without a same-edge read is dropped and flagged
module fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             drop
);
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, drop_q, drop_d, rd, wr;
  logic [1:0] count_q, count_d;
  always_comb begin
    rd       = rd_en && count_q != 2'd0;
    wr       = wr_en && (count_q != 2'd2 || rd);
    drop_d   = wr_en && !wr;
    wr_ptr_d = wr_ptr_q ^ wr;
    rd_ptr_d = rd_ptr_q ^ rd;
    count_d  = count_q + {1'b0, wr} - {1'b0, rd};
    mem_d    = mem_q;
    if (wr) mem_d[wr_ptr_q] = wr_data;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  // storage is deliberately left out of reset; only the pointers matter
  always_ff @(posedge i_clk) mem_q <= mem_d;
  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = count_q == 2'd0;
  assign full    = count_q == 2'd2;
  assign drop    = drop_q;
endmodule

// File: rtl/decim_round_sat.sv
// decim_round_sat: keep every DECIM-th strobed sample, round-shift, saturate and buffer it
module decim_round_sat
  import boxcar_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int DECIM     = DEF_DECIM
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_ce,
  input  logic [IN_WIDTH-1:0]  i_data,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_sat,
  output logic                 o_drop
);
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int SW = IN_WIDTH + 1;
  localparam logic signed [SW-1:0] RND  = SW'((1 << SHIFT) >> 1);
  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(OUT_WIDTH));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(OUT_WIDTH));
  logic [PW-1:0] phase_q, phase_d;
  logic s1_valid_q, s1_valid_d, sat_q, sat_d, keep, clip, fifo_empty, fifo_full;
  logic [OUT_WIDTH-1:0] s1_data_q, s1_data_d, clamped;
  logic signed [SW-1:0] sum, shifted;
  always_comb begin
    keep       = i_ce && phase_q == '0;
    sum        = $signed({i_data[IN_WIDTH-1], i_data}) + RND;
    shifted    = sum >>> SHIFT;
    clip       = shifted > MAXV || shifted < MINV;
    clamped    = shifted > MAXV ? MAXV[OUT_WIDTH-1:0] :
                 shifted < MINV ? MINV[OUT_WIDTH-1:0] : shifted[OUT_WIDTH-1:0];
    phase_d    = !i_ce ? phase_q : phase_q == PW'(DECIM - 1) ? '0 : phase_q + 1'b1;
    s1_valid_d = keep;
    s1_data_d  = keep ? clamped : s1_data_q;
    sat_d      = sat_q | (keep & clip);
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      sat_q      <= sat_d;
    end
  always_ff @(posedge i_clk) s1_data_q <= s1_data_d;
  fifo2 #(.WIDTH(OUT_WIDTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .wr_en     (s1_valid_q),
    .wr_data   (s1_data_q),
    .rd_en     (i_ready),
    .rd_data   (o_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (o_drop)
  );
  assert property (@(posedge i_clk) disable iff (!i_reset_n) !(fifo_full && fifo_empty));
  assign o_valid = !fifo_empty;
  assign o_sat   = sat_q;
endmodule

// File: tb/tb_decim_round_sat.sv
// tb_decim_round_sat: scoreboard bench over three parameterisations sharing one stimulus bus
module tb_decim_round_sat;
  typedef struct {int val; int due;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, ready = 1'b0;
  logic [8:0] d9 = '0;
  logic signed [7:0] a_data, b_data, c_data;
  logic a_valid, a_sat, a_drop, b_valid, b_sat, b_drop, c_valid, c_sat, c_drop;
  int checks = 0, failures = 0, cyc = 0, sel = 0, da = 0, db = 0, dc = 0, d0;
  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decim_round_sat #(.IN_WIDTH(8), .OUT_WIDTH(8), .SHIFT(0), .DECIM(2)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(d9[7:0]), .o_data(a_data),
    .o_valid(a_valid), .i_ready(ready), .o_sat(a_sat), .o_drop(a_drop));
  decim_round_sat #(.IN_WIDTH(9), .OUT_WIDTH(8), .SHIFT(1), .DECIM(1)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(d9), .o_data(b_data),
    .o_valid(b_valid), .i_ready(ready), .o_sat(b_sat), .o_drop(b_drop));
  decim_round_sat #(.IN_WIDTH(9), .OUT_WIDTH(8), .SHIFT(0), .DECIM(1)) decim_round_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(d9), .o_data(c_data),
    .o_valid(c_valid), .i_ready(ready), .o_sat(c_sat), .o_drop(c_drop));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int v, input bit timed);
    exp_t e;
    e.val = v;
    e.due = timed ? cyc + 2 : -1;
    if (sel == 0) qa.push_back(e);
    else if (sel == 1) qb.push_back(e);
    else qc.push_back(e);
  endtask

  task automatic take(input int s, input int v);
    exp_t e;
    int n;
    n = s == 0 ? qa.size() : s == 1 ? qb.size() : qc.size();
    if (n == 0) begin
      chk("unexpected_output", v, 99999);
      return;
    end
    if (s == 0) e = qa.pop_front();
    else if (s == 1) e = qb.pop_front();
    else e = qc.pop_front();
    chk("data", v, e.val);
    if (e.due >= 0) chk("latency", cyc, e.due);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (a_drop) da++;
    if (b_drop) db++;
    if (c_drop) dc++;
    if (ready && sel == 0 && a_valid) take(0, a_data);
    if (ready && sel == 1 && b_valid) take(1, b_data);
    if (ready && sel == 2 && c_valid) take(2, c_data);
  end

  task automatic step(input bit c, input int x);
    ce = c;
    d9 = 9'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ce = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    ce = 1'b0;
    ready = 1'b0;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    qc.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_c_sat", c_sat, 0);
    chk("rst_b_drop", b_drop, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // decimate by 2, first strobe after reset is kept
    sel = 0;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(i, 1'b1);
      step(1'b1, i);
    end
    idle(4);
    chk("decim_drain", qa.size(), 0);
    // round half up with SHIFT=1
    rst_pulse();
    sel = 1;
    ready = 1'b1;
    push(2, 1'b0); step(1'b1, 3);
    push(-1, 1'b0); step(1'b1, -3);
    push(3, 1'b0); step(1'b1, 5);
    idle(4);
    chk("round_drain", qb.size(), 0);
    // saturation and sticky o_sat
    rst_pulse();
    sel = 2;
    ready = 1'b1;
    chk("sat_before", c_sat, 0);
    push(127, 1'b0); step(1'b1, 200);
    chk("sat_rise", c_sat, 1);
    push(-128, 1'b0); step(1'b1, -256);
    push(5, 1'b0); step(1'b1, 5);
    idle(4);
    chk("sat_sticky", c_sat, 1);
    chk("sat_drain", qc.size(), 0);
    // backpressure: third sample dropped, head held
    rst_pulse();
    sel = 1;
    d0 = db;
    push(10, 1'b0); step(1'b1, 20);
    push(11, 1'b0); step(1'b1, 22);
    step(1'b1, 24);
    idle(3);
    chk("bp_valid", b_valid, 1);
    chk("bp_head", b_data, 10);
    chk("bp_drops", db - d0, 1);
    idle(2);
    chk("bp_hold", b_data, 10);
    chk("bp_drop_once", db - d0, 1);
    ready = 1'b1;
    idle(4);
    chk("bp_drain", qb.size(), 0);
    // full FIFO with read and write on the same edge
    rst_pulse();
    sel = 1;
    d0 = db;
    push(1, 1'b0); step(1'b1, 2);
    push(2, 1'b0); step(1'b1, 4);
    push(3, 1'b0); step(1'b1, 6);
    ready = 1'b1;
    idle(5);
    chk("full_rw_nodrop", db - d0, 0);
    chk("full_rw_drain", qb.size(), 0);
    // asynchronous reset with two buffered samples
    rst_pulse();
    sel = 0;
    push(-56, 1'b0); step(1'b1, 200);
    step(1'b1, 1);
    push(60, 1'b0); step(1'b1, 60);
    idle(2);
    chk("mid_valid_pre", a_valid, 1);
    chk("mid_sat_pre", c_sat, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_valid_async", a_valid, 0);
    chk("mid_sat_async", c_sat, 0);
    chk("mid_drop_async", a_drop, 0);
    qa.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    push(33, 1'b1); step(1'b1, 33);
    step(1'b1, 34);
    idle(4);
    chk("post_reset_drain", qa.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
